rv_bank_rsp_merge: RTL
======================

// Module: rv_bank_rsp_merge
// PURPOSE
//  Merges per-bank cache responses into one response stream for the core.
//  - Round-robin arbitration across NUM_BANKS valid/ready bank response ports.
//  - Re-inserts the winning bank index into the response tag at TAG_SEL_POS,
//    using RV_bits_insert (N=TAG_WIDTH, S=BANK_SEL_BITS, POS=TAG_SEL_POS).
//  - Registers the merged response in a one-entry output pipe register.
//  - Sits between the cache bank array and the core response port.
// PARAMETERS
//  NUM_BANKS      4   number of bank response ports; must be >= 2
//  DATA_WIDTH     32  response data width per bank
//  TAG_WIDTH      8   bank-local tag width (bank bits already stripped)
//  TAG_SEL_POS    0   bit position where the bank index is inserted; 0..TAG_WIDTH
//  BANK_SEL_BITS  $clog2(NUM_BANKS)  localparam, bank index width
// PORTS
//  clk             in   1                          clock, all logic rising-edge
//  reset           in   1                          synchronous, active-high
//  bank_rsp_valid  in   NUM_BANKS                  per-bank response valid
//  bank_rsp_data   in   NUM_BANKS*DATA_WIDTH       bank i at [i*DATA_WIDTH +: DATA_WIDTH]
//  bank_rsp_tag    in   NUM_BANKS*TAG_WIDTH        bank i at [i*TAG_WIDTH +: TAG_WIDTH]
//  bank_rsp_ready  out  NUM_BANKS                  per-bank accept, combinational
//  rsp_valid       out  1                          merged response valid (registered)
//  rsp_data        out  DATA_WIDTH                 merged response data (registered)
//  rsp_tag         out  TAG_WIDTH+BANK_SEL_BITS    tag with bank index inserted (registered)
//  rsp_ready       in   1                          downstream accept
// BEHAVIOUR
//  Reset (synchronous): rsp_valid=0, rsp_data=0, rsp_tag=0, rr_ptr=0.
//  - A reset mid-operation discards any held response; no bank is acked that cycle.
//  Pipe readiness: pipe_ready = !rsp_valid || rsp_ready.
//  Arbitration, combinational:
//  - Winner is the first valid bank scanning rr_ptr, rr_ptr+1, ... modulo NUM_BANKS.
//  - grant is one-hot or zero.
//  - bank_rsp_ready[i] = grant[i] && pipe_ready. Exactly one bank transfers per accept.
//  - bank_rsp_ready never depends on bank_rsp_valid of other banks except through grant.
//  Pointer update:
//  - On an accepted transfer (any bank_rsp_valid[i] && bank_rsp_ready[i]),
//    rr_ptr <= (winner+1) mod NUM_BANKS.
//  - Otherwise rr_ptr holds. A stall does not rotate priority.
//  Output register:
//  - On an accepted transfer: rsp_valid<=1, rsp_data<=winner data,
//    rsp_tag<=insert(winner tag, winner index).
//  - Else if rsp_ready: rsp_valid<=0, and rsp_data/rsp_tag hold their last value.
//  - Else (rsp_valid && !rsp_ready): all outputs hold stable.
//  Latency and throughput:
//  - Bank accept to rsp_valid is 1 cycle.
//  - Full throughput of 1 response/cycle when rsp_ready=1; simultaneous drain and
//    load in the same cycle is allowed.
//  Tag insertion width rules:
//  - TAG_SEL_POS=0: rsp_tag = {tag, idx}.
//  - TAG_SEL_POS=TAG_WIDTH: rsp_tag = {idx, tag}.
//  - Otherwise: rsp_tag = {tag[TAG_WIDTH-1:POS], idx, tag[POS-1:0]}.
//  - idx is the bank number, zero-extended to BANK_SEL_BITS.
//  No valid banks: grant=0, no transfer, rsp_valid drains per rsp_ready.
//  Fairness: with all banks continuously valid and rsp_ready=1, the grant order is
//  strictly 0,1,..,NUM_BANKS-1 repeating from reset.
// TESTING
//  1. Reset held 2 cycles with all banks valid
//     -> rsp_valid=0, rsp_data=0, rsp_tag=0, bank_rsp_ready=0 during reset.
//  2. Single response, defaults: bank 2 valid, tag=8'hA5, data=32'hDEADBEEF, rsp_ready=1
//     -> next cycle rsp_valid=1, rsp_data=32'hDEADBEEF, rsp_tag=10'h296 ({A5,2'b10}).
//  3. All 4 banks valid continuously, rsp_ready=1
//     -> grants 0,1,2,3,0 on consecutive cycles; rsp_valid stays 1.
//  4. Backpressure: rsp_valid=1 with rsp_ready=0 for 3 cycles and banks 1,3 valid
//     -> bank_rsp_ready=0, outputs stable, rr_ptr unchanged.
//     Then raise rsp_ready -> bank 1 accepted, bank 3 next.
//  5. TAG_SEL_POS=TAG_WIDTH=8, bank 3, tag=8'h01 -> rsp_tag=10'h301.
//     TAG_SEL_POS=4, bank 1, tag=8'hF0 -> rsp_tag=10'h3D0.
//  6. Reset asserted while rsp_valid=1 and rsp_ready=0
//     -> next cycle rsp_valid=0, rr_ptr=0, held response lost, no bank acked.

Source files
------------

// File: rtl/rv_bank_rsp_merge_if.sv
// Bank-response merge bundle: per-bank response ports in, merged core response out.
// Latency: none, wires only.
// Backpressure: bank_rsp_ready per bank, rsp_ready from the core.
// Ports: bank_rsp_valid/data/tag/ready (per bank, packed bank-major),
//        rsp_valid/data/tag/ready (merged, tag widened by the bank index).
interface rv_bank_rsp_merge_if #(
  parameter int NUM_BANKS     = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int TAG_WIDTH     = 8,
  parameter int BANK_SEL_BITS = $clog2(NUM_BANKS)
);
  logic [NUM_BANKS-1:0]              bank_rsp_valid;
  logic [NUM_BANKS*DATA_WIDTH-1:0]   bank_rsp_data;
  logic [NUM_BANKS*TAG_WIDTH-1:0]    bank_rsp_tag;
  logic [NUM_BANKS-1:0]              bank_rsp_ready;
  logic                              rsp_valid;
  logic [DATA_WIDTH-1:0]             rsp_data;
  logic [TAG_WIDTH+BANK_SEL_BITS-1:0] rsp_tag;
  logic                              rsp_ready;

  // master: the merge block itself
  modport master (
    input  bank_rsp_valid, bank_rsp_data, bank_rsp_tag, rsp_ready,
    output bank_rsp_ready, rsp_valid, rsp_data, rsp_tag
  );

  // slave: the environment (bank array plus core)
  modport slave (
    output bank_rsp_valid, bank_rsp_data, bank_rsp_tag, rsp_ready,
    input  bank_rsp_ready, rsp_valid, rsp_data, rsp_tag
  );
endinterface

// File: rtl/rv_bank_rsp_merge.sv
// Merges NUM_BANKS cache bank responses into one core response stream (round-robin).
// Latency: 1 cycle from bank accept to rsp_valid; 1 response/cycle when rsp_ready=1.
// Backpressure: banks are acked only when the output register is empty or draining.
// Ports: clk, reset (sync, active-high), bus (rv_bank_rsp_merge_if.master) carrying
//        the per-bank valid/data/tag/ready ports and the merged rsp_* port.
module rv_bank_rsp_merge #(
  parameter int NUM_BANKS   = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 8,
  parameter int TAG_SEL_POS = 0
) (
  input  logic clk,
  input  logic reset,
  rv_bank_rsp_merge_if.master bus
);
  localparam int BANK_SEL_BITS = $clog2(NUM_BANKS);
  localparam int OUT_TAG_W     = TAG_WIDTH + BANK_SEL_BITS;

  // Re-insert the bank index into the bank-local tag at TAG_SEL_POS. Done with
  // masks and shifts so POS=0 and POS=TAG_WIDTH need no special-case slices.
  function automatic logic [OUT_TAG_W-1:0] bits_insert(
    input logic [TAG_WIDTH-1:0]     tag,
    input logic [BANK_SEL_BITS-1:0] idx
  );
    logic [OUT_TAG_W-1:0] t_ext;
    logic [OUT_TAG_W-1:0] i_ext;
    logic [OUT_TAG_W-1:0] lo_mask;
    t_ext   = OUT_TAG_W'(tag);
    i_ext   = OUT_TAG_W'(idx);
    lo_mask = (OUT_TAG_W'(1) << TAG_SEL_POS) - OUT_TAG_W'(1);
    return ((t_ext & ~lo_mask) << BANK_SEL_BITS) | (i_ext << TAG_SEL_POS) | (t_ext & lo_mask);
  endfunction

  logic [BANK_SEL_BITS-1:0] rr_ptr;
  logic [BANK_SEL_BITS-1:0] winner;
  logic [BANK_SEL_BITS-1:0] cand;
  logic                     found;
  logic [NUM_BANKS-1:0]     grant;
  logic                     pipe_ready;
  logic                     xfer;
  logic [DATA_WIDTH-1:0]    win_data;
  logic [TAG_WIDTH-1:0]     win_tag;

  logic                     rsp_valid_q;
  logic [DATA_WIDTH-1:0]    rsp_data_q;
  logic [OUT_TAG_W-1:0]     rsp_tag_q;

  // First valid bank scanning from rr_ptr upward, wrapping modulo NUM_BANKS.
  always_comb begin
    grant  = '0;
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int off = 0; off < NUM_BANKS; off++) begin
      cand = BANK_SEL_BITS'((int'(rr_ptr) + off) % NUM_BANKS);
      if (!found && bus.bank_rsp_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    if (found) grant[winner] = 1'b1;
  end

  assign win_data = bus.bank_rsp_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
  assign win_tag  = bus.bank_rsp_tag[int'(winner)*TAG_WIDTH +: TAG_WIDTH];

  // Reset suppresses every ack so a response presented during reset is not lost.
  assign pipe_ready         = !rsp_valid_q || bus.rsp_ready;
  assign bus.bank_rsp_ready = (pipe_ready && !reset) ? grant : '0;
  assign xfer               = found && pipe_ready && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else if (xfer) begin
      // Priority rotates only on an actual transfer, never on a stall.
      rr_ptr      <= BANK_SEL_BITS'((int'(winner) + 1) % NUM_BANKS);
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= win_data;
      rsp_tag_q   <= bits_insert(win_tag, winner);
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_tag   = rsp_tag_q;
endmodule
